// File: rtl/arcade_input_pkg.sv
// Shared constants for the galaxian input-conditioning stage.
// Scan codes, CSJUDLR and joystick bit indices, coin FSM states.
package arcade_input_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_LCTRL = 8'h14;
  localparam logic [7:0] KEY_F1    = 8'h05;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_F2    = 8'h06;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_G     = 8'h34;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_T     = 8'h2C;

  localparam int B_COIN  = 6;
  localparam int B_START = 5;
  localparam int B_FIRE  = 4;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  localparam int J_RIGHT  = 0;
  localparam int J_LEFT   = 1;
  localparam int J_DOWN   = 2;
  localparam int J_UP     = 3;
  localparam int J_FIRE   = 4;
  localparam int J_START1 = 5;
  localparam int J_START2 = 6;
  localparam int J_COIN   = 7;

  localparam int K_UP      = 0;
  localparam int K_DOWN    = 1;
  localparam int K_LEFT    = 2;
  localparam int K_RIGHT   = 3;
  localparam int K_FIRE_A  = 4;
  localparam int K_FIRE_B  = 5;
  localparam int K_ST1_A   = 6;
  localparam int K_ST1_B   = 7;
  localparam int K_ST2_A   = 8;
  localparam int K_ST2_B   = 9;
  localparam int K_COIN1   = 10;
  localparam int K_COIN2   = 11;
  localparam int K_P2_UP   = 12;
  localparam int K_P2_DOWN = 13;
  localparam int K_P2_LEFT = 14;
  localparam int K_P2_RGT  = 15;
  localparam int K_P2_FIRE = 16;
  localparam int K_SERVICE = 17;
  localparam int K_NUM     = 18;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } coin_state_t;

  // udlr = {up,down,left,right}; horizontal cabinet turns the stick
  function automatic logic [3:0] remap(
    input logic       rot,
    input logic [3:0] udlr
  );
    return rot ? {udlr[1], udlr[0], udlr[2], udlr[3]} : udlr;
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// Fixed-width coin pulse generator with one-deep pending request.
// Rising edge of req starts a pulse; a forced low gap follows.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 600000,
  parameter int COIN_GAP_CYC   = 600000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin
);

  localparam int MAXC = (COIN_PULSE_CYC > COIN_GAP_CYC) ?
                        COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LAST = CW'(COIN_PULSE_CYC - 1);
  localparam logic [CW-1:0] G_LAST = CW'(COIN_GAP_CYC - 1);

  coin_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend, pend_n;
  logic          req_q;
  logic          req_rise;

  assign req_rise = req & ~req_q;
  assign coin     = (state == PULSE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      req_q <= req;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    unique case (state)
      IDLE: begin
        if (req_rise) begin
          state_n = PULSE;
          cnt_n   = '0;
        end
      end
      PULSE: begin
        pend_n = pend | req_rise;
        if (cnt == P_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == G_LAST) begin
          cnt_n   = '0;
          pend_n  = 1'b0;
          state_n = (pend | req_rise) ? PULSE : IDLE;
        end else begin
          cnt_n  = cnt + 1'b1;
          pend_n = pend | req_rise;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// PS/2 + joystick conditioning for the galaxian core.
// Held key states, orientation remap and debounced coin pulses.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 600000,
  parameter int COIN_GAP_CYC   = 600000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [6:0]  p1_csjudlr,
  output logic [6:0]  p2_csjudlr,
  output logic        service
);

  logic             old_toggle;
  logic             key_evt;
  logic [K_NUM-1:0] keys;
  logic [K_NUM-1:0] key_sel;
  logic [7:0]       code;
  logic             ext;
  logic [3:0]       p1_raw, p2_raw;
  logic             p1_start, p2_start;
  logic             p1_fire, p2_fire;
  logic             p1_coin_req, p2_coin_req;
  logic [5:0]       p1_q, p2_q;
  logic             p1_coin, p2_coin;
  logic             unused_joy;

  assign code    = ps2_key[7:0];
  assign ext     = ps2_key[8];
  assign key_evt = ps2_key[10] != old_toggle;

  assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8],
                        joystick_1[J_START1]};

  always_comb begin
    key_sel = '0;
    unique case (1'b1)
      code == KEY_UP:           key_sel[K_UP]      = 1'b1;
      code == KEY_DOWN:         key_sel[K_DOWN]    = 1'b1;
      code == KEY_LEFT:         key_sel[K_LEFT]    = 1'b1;
      code == KEY_RIGHT:        key_sel[K_RIGHT]   = 1'b1;
      !ext && code == KEY_SPACE: key_sel[K_FIRE_A] = 1'b1;
      !ext && code == KEY_LCTRL: key_sel[K_FIRE_B] = 1'b1;
      !ext && code == KEY_F1:   key_sel[K_ST1_A]   = 1'b1;
      !ext && code == KEY_1:    key_sel[K_ST1_B]   = 1'b1;
      !ext && code == KEY_F2:   key_sel[K_ST2_A]   = 1'b1;
      !ext && code == KEY_2:    key_sel[K_ST2_B]   = 1'b1;
      !ext && code == KEY_5:    key_sel[K_COIN1]   = 1'b1;
      !ext && code == KEY_6:    key_sel[K_COIN2]   = 1'b1;
      !ext && code == KEY_R:    key_sel[K_P2_UP]   = 1'b1;
      !ext && code == KEY_F:    key_sel[K_P2_DOWN] = 1'b1;
      !ext && code == KEY_D:    key_sel[K_P2_LEFT] = 1'b1;
      !ext && code == KEY_G:    key_sel[K_P2_RGT]  = 1'b1;
      !ext && code == KEY_A:    key_sel[K_P2_FIRE] = 1'b1;
      !ext && code == KEY_T:    key_sel[K_SERVICE] = 1'b1;
      default:                  key_sel = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_toggle <= ps2_key[10];
      keys       <= '0;
    end else begin
      old_toggle <= ps2_key[10];
      if (key_evt)
        keys <= (keys & ~key_sel) | (key_sel & {K_NUM{ps2_key[9]}});
    end
  end

  assign p1_raw = {
    keys[K_UP]    | joystick_0[J_UP],
    keys[K_DOWN]  | joystick_0[J_DOWN],
    keys[K_LEFT]  | joystick_0[J_LEFT],
    keys[K_RIGHT] | joystick_0[J_RIGHT]
  };
  assign p2_raw = {
    keys[K_P2_UP]   | joystick_1[J_UP],
    keys[K_P2_DOWN] | joystick_1[J_DOWN],
    keys[K_P2_LEFT] | joystick_1[J_LEFT],
    keys[K_P2_RGT]  | joystick_1[J_RIGHT]
  };

  assign p1_fire  = keys[K_FIRE_A] | keys[K_FIRE_B] | joystick_0[J_FIRE];
  assign p2_fire  = keys[K_P2_FIRE] | joystick_1[J_FIRE];
  assign p1_start = keys[K_ST1_A] | keys[K_ST1_B] | joystick_0[J_START1];
  assign p2_start = keys[K_ST2_A] | keys[K_ST2_B] |
                    joystick_1[J_START2] | joystick_0[J_START2];

  // pressing either start also drops a coin for convenience
  assign p1_coin_req = keys[K_COIN1] | joystick_0[J_COIN] |
                       p1_start | p2_start;
  assign p2_coin_req = keys[K_COIN2] | joystick_1[J_COIN];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p1_q    <= '0;
      p2_q    <= '0;
      service <= 1'b0;
    end else begin
      p1_q    <= {p1_start, p1_fire, remap(rotate, p1_raw)};
      p2_q    <= {p2_start, p2_fire, remap(rotate, p2_raw)};
      service <= keys[K_SERVICE];
    end
  end

  coin_pulser #(
    .COIN_PULSE_CYC(COIN_PULSE_CYC),
    .COIN_GAP_CYC  (COIN_GAP_CYC)
  ) u_coin1 (
    .clk_sys(clk_sys),
    .reset  (reset),
    .req    (p1_coin_req),
    .coin   (p1_coin)
  );

  coin_pulser #(
    .COIN_PULSE_CYC(COIN_PULSE_CYC),
    .COIN_GAP_CYC  (COIN_GAP_CYC)
  ) u_coin2 (
    .clk_sys(clk_sys),
    .reset  (reset),
    .req    (p2_coin_req),
    .coin   (p2_coin)
  );

  assign p1_csjudlr = {p1_coin, p1_q};
  assign p2_csjudlr = {p2_coin, p2_q};

endmodule
